// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin ring arbiter: FSM state encoding,
// a constant clog2 helper and a one-hot to binary encoder.
package arb_pkg;

    // Two-state arbiter FSM: nobody owns the resource, or exactly one owner.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    // Widest vector the encoder accepts (upper bound of the requester count).
    localparam int ONEHOT_MAX_W = 16;
    localparam int BIN_MAX_W    = 4;

    // Number of bits needed to hold values 0..n-1 (at least 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // One-hot to binary encoder; an all-zero input encodes as 0.
    function automatic logic [BIN_MAX_W-1:0] onehot_to_bin(input logic [ONEHOT_MAX_W-1:0] oh);
        logic [BIN_MAX_W-1:0] b;
        b = '0;
        for (int k = 0; k < ONEHOT_MAX_W; k++) begin
            if (oh[k]) begin
                b = b | BIN_MAX_W'(k);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_ring_arbiter_onehot_rotator.sv
// One-hot priority pointer. On rotate it loads the given one-hot source
// rotated up by one position (bit N-1 wraps to bit 0); clear returns it to bit 0.
module onehot_rotator #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         rot_en_i,
    input  logic [N-1:0] src_i,
    output logic [N-1:0] q_o
);

    localparam logic [N-1:0] RESET_VAL = N'(1);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Next pointer: hold, or the source rotated up by one on a release.
    always_comb begin
        // NOTE: default assignment first so every path drives q_d and no latch is inferred.
        q_d = q_q;
        if (rot_en_i) begin
            q_d = {src_i[N-2:0], src_i[N-1]};
        end
    end

    // Pointer register with synchronous clear taking precedence over rotation.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
        if (clear) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer. A grant is
// held while its owner keeps requesting, for at most MAX_HOLD cycles, and
// every release is followed by exactly one idle cycle.
module rr_ring_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [N-1:0]        req,
    output logic [N-1:0]        grant,
    output logic                grant_valid,
    output logic [clog2(N)-1:0] grant_idx,
    output logic [N-1:0]        ptr
);

    localparam int         IDX_W     = clog2(N);
    localparam int         W2        = 2 * N;
    localparam int         HOLD_W    = 8;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e              state_q;
    logic [N-1:0]        grant_q;
    logic                grant_valid_q;
    logic [IDX_W-1:0]    grant_idx_q;
    logic [HOLD_W-1:0]   hold_q;

    logic [N-1:0]        ptr_w;
    logic [N-1:0]        therm_w;
    logic [W2-1:0]       masked_w;
    logic [W2-1:0]       lowest_w;
    logic [N-1:0]        pick_w;
    logic [IDX_W-1:0]    pick_idx_w;
    logic                owner_req_w;
    logic                release_w;

    // Circular priority select: requests at or above the pointer occupy the
    // low half, the full request vector the high half (the wrapped search).
    // Isolating the lowest set bit and folding both halves gives the winner.
    assign therm_w    = ~(ptr_w - N'(1));
    assign masked_w   = {req, req & therm_w};
    assign lowest_w   = masked_w & (~masked_w + W2'(1));
    assign pick_w     = lowest_w[N-1:0] | lowest_w[W2-1:N];
    assign pick_idx_w = IDX_W'(onehot_to_bin(ONEHOT_MAX_W'(pick_w)));

    // The owner gives up the resource when it stops requesting or its burst is spent.
    assign owner_req_w = |(req & grant_q);
    assign release_w   = (state_q == S_GRANT) && (!owner_req_w || (hold_q == HOLD_LAST));

    onehot_rotator #(
        .N (N)
    ) u_ptr (
        .clk      (clk),
        .clear    (clear),
        .rot_en_i (release_w),
        .src_i    (grant_q),
        .q_o      (ptr_w)
    );

    // Arbiter FSM with registered grant outputs and burst counter.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            hold_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        state_q       <= S_GRANT;
                        grant_q       <= pick_w;
                        grant_valid_q <= 1'b1;
                        grant_idx_q   <= pick_idx_w;
                        hold_q        <= '0;
                    end
                end
                S_GRANT: begin
                    if (release_w) begin
                        state_q       <= S_IDLE;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        grant_idx_q   <= '0;
                        hold_q        <= '0;
                    end else if (hold_q != HOLD_LAST) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign ptr         = ptr_w;

endmodule

// File: doc/rr_ring_arbiter.md
# rr_ring_arbiter

Round-robin arbiter that shares a single resource among N requesters. A one-hot rotating priority pointer, the same ring-counter idea used elsewhere in the sequential library, decides who goes next. A grant is held while the owner keeps requesting, up to a burst limit. The block sits in front of any shared datapath (bus, memory port, counter bank) and drives its select lines.

## Interface
- N, 4, number of requesters; legal range 2..16
- MAX_HOLD, 8, maximum consecutive grant cycles per owner; legal range 1..255
- clk  in  1  rising-edge clock
- clear  in  1  synchronous, active-high reset
- req  in  N  request vector; bit k is requester k
- grant  out  N  one-hot grant, registered; all-zero when idle
- grant_valid  out  1  OR of grant, registered
- grant_idx  out  clog2(N)  binary index of the current owner; 0 when idle
- ptr  out  N  one-hot priority pointer, exported for debug

## Operation
- Two states: IDLE (grant = 0) and GRANT (exactly one grant bit set).
- **IDLE behaviour:**
  - If req is nonzero, select the first set req bit at or after ptr, searching upward circularly with wrap from N-1 to 0.
  - Register the selection into grant and grant_idx, clear hold_cnt to 0, and go to GRANT.
  - If req = 0, stay in IDLE.
- **GRANT behaviour:**
  - Each cycle, hold_cnt increments, saturating at MAX_HOLD-1.
  - Release when req[owner] = 0 or hold_cnt = MAX_HOLD-1.
  - On release: next state is IDLE, grant = 0, and ptr = owner rotated up by one (owner N-1 wraps to bit 0).
  - Otherwise the grant is held unchanged.
- ptr changes only on release or clear. It is always exactly one-hot.
- Requests from non-owners have no effect during GRANT.
- There is no preemption.
- MAX_HOLD = 1 gives one-cycle grants, each followed by a one-cycle idle gap.

## Timing
- **Reset:** clear sampled high at a clk edge sets the following values at that edge. clear takes precedence over all other inputs.
  - state = IDLE
  - grant = 0, grant_valid = 0, grant_idx = 0
  - ptr = 1 (bit 0), hold_cnt = 0
- **Arbitration latency:** req seen in IDLE at edge t produces grant visible after edge t (one-cycle registered latency).
- **Burst length:** an owner that keeps requesting receives exactly MAX_HOLD consecutive grant cycles.
- **Handover gap:** exactly one idle cycle (grant = 0) separates consecutive grants, including re-grant to the same requester.
- **Owner drops req** in cycle c, sampled at edge c+1:
  - grant falls at edge c+1;
  - the new grant appears at edge c+2.
- **Clear mid-grant:** grant drops at the next edge and ptr returns to bit 0. No partial state survives.
- **Simultaneous requests:** the pointer order decides, never the lowest index.
- **Single requester:** it is re-granted after each one-cycle gap indefinitely.

## Structure
- **Shared package `arb_pkg`:**
  - state encoding localparams S_IDLE = 1'b0, S_GRANT = 1'b1;
  - clog2 constant function;
  - one-hot-to-binary function, also used for grant_idx.
- **Sub-module `onehot_rotator`:** N-bit one-hot register with synchronous active-high clear (reset value bit 0) and a rotate-up enable, driven by the release pulse.
- **Pick logic** (circular priority select from ptr and req) is combinational:
  - implemented as double-width masking of {req, req} against a thermometer mask derived from ptr;
  - then folding the result back to N bits.

## Test plan
- **Reset and idle:** assert clear with req = 4'b1111 → grant = 0, ptr = 4'b0001 on the next edge; release clear → grant = 4'b0001, grant_idx = 0 one edge later.
- **Burst limit:** MAX_HOLD = 3, req = 4'b0001 held → grant high for 3 cycles, 1 idle cycle, then grant = 4'b0001 again; ptr = 4'b0010 after the first release.
- **Round-robin fairness:** req = 4'b1111 constant, MAX_HOLD = 2 → grants cycle through 0, 1, 2, 3, 0. Each grant lasts 2 cycles, with 1-cycle gaps between them.
- **Wrap-around:**
  - Step 1: ptr = 4'b1000 (after owner 2 releases), req = 4'b0011 → grant = 4'b0001.
  - Step 2: after owner 0 releases, ptr = 4'b0010 → next grant = 4'b0010.
- **Early release:** owner 1 granted, drops req after 2 cycles while MAX_HOLD = 8 → grant falls on the next edge and ptr = 4'b0100; requester 2, if requesting, is granted one edge later.
- **Clear mid-grant:** assert clear during owner 2's burst → grant = 0 and ptr = 4'b0001 after the edge; with req = 4'b0100 held, grant = 4'b0100 one edge after clear deasserts.
